opcode_fetch_unit: RTL and testbench

- Front-end producer of the opcode stream consumed by the stage-2 control code generator.
- Reads instruction bytes from synchronous program memory and assembles each instruction: opcode, plus an operand byte for <od> forms.
- Presents one complete instruction per valid cycle.
- Honours the downstream hold and bubble request (BB) and PC redirects (LPC) from the branch and call path.

---
 rtl/opcode_fetch_unit.sv | 103 ++++++++++
 tb/tb_opcode_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/opcode_fetch_unit.sv
// opcode_fetch_unit: fetches program bytes and presents complete opcode/operand instructions
// Optional feature: define FETCH_STALL_COUNT_EN to add the stall_cnt output.
module opcode_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        opcode,
    output logic [7:0]        operand,
    output logic              instr_valid,
`ifdef FETCH_STALL_COUNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [ADDR_W-1:0] pc_out
);
    typedef enum logic [1:0] {PRIME, OPC, OPD} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, rd_addr, opc_pc;
    logic [7:0]        opc_hold;
    logic              rd_pending, en, od, take_opc, single, pair;

    assign en       = !hold || load_pc;
    assign mem_en   = !rst && en;
    assign mem_addr = pc;
    assign od = mem_rdata == 8'h03 || mem_rdata == 8'h05 ||
                (mem_rdata[7:4] == 4'h3 && !mem_rdata[3]) ||
                (mem_rdata[3] && (mem_rdata[7:4] == 4'h0 || mem_rdata[7:4] == 4'h5 ||
                                  (mem_rdata[7:4] >= 4'h8 && mem_rdata[7:4] != 4'hF)));

    // next state and which instruction (if any) completes with the current byte
    always_comb begin
        state_nxt = state;
        take_opc  = 1'b0;
        single    = 1'b0;
        pair      = 1'b0;
        case (state)
            PRIME: state_nxt = OPC;
            OPC: begin
                take_opc  = rd_pending && od;
                single    = rd_pending && !od;
                state_nxt = take_opc ? OPD : OPC;
            end
            OPD: begin
                pair      = rd_pending;
                state_nxt = rd_pending ? OPC : OPD;
            end
            default: state_nxt = PRIME;
        endcase
        if (load_pc) state_nxt = PRIME;
        else if (hold) state_nxt = state;
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= PRIME;
        else state <= state_nxt;

    // fetch pointer, opcode staging and registered instruction outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rd_pending  <= 1'b0;
            rd_addr     <= '0;
            opc_hold    <= 8'h00;
            opc_pc      <= '0;
            opcode      <= 8'h00;
            operand     <= 8'h00;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else if (load_pc) begin
            pc          <= new_pc;
            rd_pending  <= 1'b0;
            opcode      <= 8'h00;
            operand     <= 8'h00;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else if (en) begin
            pc          <= pc + 1'b1;
            rd_pending  <= 1'b1;
            rd_addr     <= pc;
            opc_hold    <= take_opc ? mem_rdata : opc_hold;
            opc_pc      <= take_opc ? rd_addr : opc_pc;
            opcode      <= single ? mem_rdata : pair ? opc_hold : 8'h00;
            operand     <= pair ? mem_rdata : 8'h00;
            instr_valid <= single || pair;
            pc_out      <= single ? rd_addr : pair ? opc_pc : '0;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    // saturating count of held cycles and post-redirect priming bubbles
    always_ff @(posedge clk or posedge rst)
        if (rst) stall_cnt <= 16'h0000;
        else if ((hold || state == PRIME) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_opcode_fetch_unit.sv
// tb_opcode_fetch_unit: directed vector table plus randomized run against a byte-stream parse model
module tb_opcode_fetch_unit;
    localparam int NT = 1024;
    logic       clk, rst, hold, load_pc;
    logic [7:0] new_pc, mem_addr, mem_rdata, opcode, operand, pc_out;
    logic       mem_en, instr_valid;
`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] c0;
`endif

    typedef struct {
        logic       v;
        logic [7:0] opc;
        logic [7:0] opd;
        logic [7:0] pc;
    } ins_t;

    typedef struct {
        logic       h;
        logic       l;
        logic [7:0] np;
        logic       v;
        logic [7:0] opc;
        logic [7:0] opd;
        logic [7:0] pc;
    } vec_t;

    logic [7:0] mem [256];
    ins_t       ends [NT];
    ins_t       exp_o;
    logic [7:0] base;
    int         k;
    int         n_chk = 0;
    int         n_err = 0;
    vec_t       vt [22];

    opcode_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .hold(hold), .load_pc(load_pc), .new_pc(new_pc),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
        .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
`ifdef FETCH_STALL_COUNT_EN
        .stall_cnt(stall_cnt),
`endif
        .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // instruction ending at each byte index of the linear stream starting at b
    function automatic void rebuild(input logic [7:0] b);
        int i;
        for (int j = 0; j < NT; j++) ends[j] = '{1'b0, 8'h00, 8'h00, 8'h00};
        i = 0;
        while (i < NT) begin
            logic [7:0] a, op;
            a  = 8'(b + i);
            op = mem[a];
            if (op inside {8'h03, 8'h05, [8'h08:8'h0F], [8'h30:8'h37], [8'h58:8'h5F],
                           [8'h88:8'h8F], [8'h98:8'h9F], [8'hA8:8'hAF], [8'hB8:8'hBF],
                           [8'hC8:8'hCF], [8'hD8:8'hDF], [8'hE8:8'hEF]}) begin
                if (i + 1 < NT) ends[i+1] = '{1'b1, op, mem[8'(a + 8'd1)], a};
                i += 2;
            end else begin
                ends[i] = '{1'b1, op, 8'h00, a};
                i++;
            end
        end
    endfunction

    function automatic void model_restart(input logic [7:0] b);
        base  = b;
        k     = 0;
        exp_o = '{1'b0, 8'h00, 8'h00, 8'h00};
        rebuild(b);
    endfunction

    // one enabled cycle delivers byte k-1, so the instruction ending there becomes visible
    function automatic void model_advance(input logic h, input logic l, input logic [7:0] np);
        if (l) model_restart(np);
        else if (!h) begin
            exp_o = (k >= 1 && k - 1 < NT) ? ends[k-1] : '{1'b0, 8'h00, 8'h00, 8'h00};
            k++;
        end
    endfunction

    task automatic step(input logic h, input logic l, input logic [7:0] np);
        hold    = h;
        load_pc = l;
        new_pc  = np;
        #1;
        chk("mem_en", 32'(mem_en), 32'(!h || l));
        chk("mem_addr", 32'(mem_addr), 32'(8'(base + k)));
        model_advance(h, l, np);
        @(negedge clk);
        chk("instr_valid", 32'(instr_valid), 32'(exp_o.v));
        chk("opcode", 32'(opcode), 32'(exp_o.opc));
        chk("operand", 32'(operand), 32'(exp_o.opd));
        chk("pc_out", 32'(pc_out), 32'(exp_o.pc));
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; load_pc = 1'b0; new_pc = 8'h00; mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'h18; mem[2] = 8'h80; mem[3] = 8'h5B; mem[4] = 8'h3C;
        mem[5] = 8'h00; mem[6] = 8'h8A; mem[7] = 8'h55; mem[8] = 8'h03; mem[9] = 8'h77;
        mem[8'h40] = 8'h22; mem[8'hFF] = 8'h05;
        vt[0]  = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
        vt[1]  = '{0, 0, 8'h00, 1, 8'h01, 8'h00, 8'h00};
        vt[2]  = '{0, 0, 8'h00, 1, 8'h18, 8'h00, 8'h01};
        vt[3]  = '{0, 0, 8'h00, 1, 8'h80, 8'h00, 8'h02};
        vt[4]  = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
        vt[5]  = '{0, 0, 8'h00, 1, 8'h5B, 8'h3C, 8'h03};
        vt[6]  = '{0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h05};
        vt[7]  = '{1, 0, 8'h00, 1, 8'h00, 8'h00, 8'h05};
        vt[8]  = '{1, 0, 8'h00, 1, 8'h00, 8'h00, 8'h05};
        vt[9]  = '{1, 0, 8'h00, 1, 8'h00, 8'h00, 8'h05};
        vt[10] = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
        vt[11] = '{0, 0, 8'h00, 1, 8'h8A, 8'h55, 8'h06};
        vt[12] = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
        vt[13] = '{0, 1, 8'h40, 0, 8'h00, 8'h00, 8'h00};
        vt[14] = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
        vt[15] = '{0, 0, 8'h00, 1, 8'h22, 8'h00, 8'h40};
        vt[16] = '{0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h41};
        vt[17] = '{1, 1, 8'hFF, 0, 8'h00, 8'h00, 8'h00};
        vt[18] = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
        vt[19] = '{0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
        vt[20] = '{0, 0, 8'h00, 1, 8'h05, 8'h01, 8'hFF};
        vt[21] = '{0, 0, 8'h00, 1, 8'h18, 8'h00, 8'h01};

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_pc_out", 32'(pc_out), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;
        model_restart(8'h00);

        for (int i = 0; i < 22; i++) begin
            step(vt[i].h, vt[i].l, vt[i].np);
            chk("tbl_valid", 32'(instr_valid), 32'(vt[i].v));
            chk("tbl_opcode", 32'(opcode), 32'(vt[i].opc));
            chk("tbl_operand", 32'(operand), 32'(vt[i].opd));
            chk("tbl_pc_out", 32'(pc_out), 32'(vt[i].pc));
        end

`ifdef FETCH_STALL_COUNT_EN
        c0 = stall_cnt;
`endif
        repeat (5) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
`ifdef FETCH_STALL_COUNT_EN
        chk("stall_cnt_delta", 32'(stall_cnt - c0), 32'd6);
`endif
        repeat (3) step(1'b0, 1'b0, 8'h00);

        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_opcode", 32'(opcode), 32'h0);
        chk("arst_operand", 32'(operand), 32'h0);
        chk("arst_pc_out", 32'(pc_out), 32'h0);
        chk("arst_mem_en", 32'(mem_en), 32'h0);
        chk("arst_mem_addr", 32'(mem_addr), 32'h0);
`ifdef FETCH_STALL_COUNT_EN
        chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_restart(8'h00);
        repeat (6) step(1'b0, 1'b0, 8'h00);

        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        rst = 1'b0;
        model_restart(8'h00);
        for (int n = 0; n < 2000; n++) begin
            logic h, l;
            h = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 24) == 0) || (k > NT - 100);
            step(h, l, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
